// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: widths, instruction field positions,
// special opcodes, the NOP instruction word and the operand-forwarding selector.
package decode_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREGS  = 8;
    localparam int unsigned ADR_W  = 3;
    localparam int unsigned INST_W = 16;
    localparam int unsigned COP_W  = 4;

    // Instruction layout: cop | dest | srcA | srcB | free
    localparam int unsigned COP_MSB  = 15;
    localparam int unsigned COP_LSB  = 12;
    localparam int unsigned DEST_MSB = 11;
    localparam int unsigned DEST_LSB = 9;
    localparam int unsigned SRCA_MSB = 8;
    localparam int unsigned SRCA_LSB = 6;
    localparam int unsigned SRCB_MSB = 5;
    localparam int unsigned SRCB_LSB = 3;
    localparam int unsigned FREE_MSB = 2;
    localparam int unsigned FREE_LSB = 0;

    localparam logic [COP_W-1:0]  NOP_COP  = 4'b1111;
    localparam logic [COP_W-1:0]  IMM_COP  = 4'b0011;
    localparam logic [INST_W-1:0] NOP_WORD = {NOP_COP, 12'h000};

    // The ALU result belongs to the instruction one ahead, so it beats whatever
    // the register file (including its same-cycle writeback bypass) returns.
    function automatic logic [DATA_W-1:0] select_operand(
        input logic              fwd_we,
        input logic [ADR_W-1:0]  fwd_adr,
        input logic [DATA_W-1:0] fwd_data,
        input logic [ADR_W-1:0]  src_adr,
        input logic [DATA_W-1:0] rf_data
    );
        if (fwd_we && (fwd_adr == src_adr)) begin
            return fwd_data;
        end
        return rf_data;
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Architectural register file: NREGS x DATA_W, one write port, two combinational
// read ports. A read of the address being written this cycle returns the write data.
// Ports:
//   clk, reset         clock, asynchronous active-low reset (clears all registers)
//   wr_en/wr_adr/wr_data  write port, committed on the rising edge
//   rd_adr_a/rd_data_a    read port A
//   rd_adr_b/rd_data_b    read port B
module decode_stage_regfile
    import decode_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADR_W-1:0]  wr_adr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADR_W-1:0]  rd_adr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADR_W-1:0]  rd_adr_b,
    output logic [DATA_W-1:0] rd_data_b
);

    logic [DATA_W-1:0] mem_q [NREGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_adr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = mem_q[rd_adr_a];
        rd_data_b = mem_q[rd_adr_b];
        if (wr_en && (wr_adr == rd_adr_a)) begin
            rd_data_a = wr_data;
        end
        if (wr_en && (wr_adr == rd_adr_b)) begin
            rd_data_b = wr_data;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: latches the fetched instruction, splits it into fields, reads two
// operands from the register file and forwards newer ALU/writeback results into them.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   enable, flush, instruction  IR load control (flush wins) and fetched word
//   alu_fwd_*                   result from the ALU stage, forwarded to operands
//   wb_*                        writeback port into the register file
//   regA, regB                  operands to the ALU stage
//   cop, destReg_adr, we        opcode, destination and its write enable
//   regA_adr, regB_adr, inst_freeBits  raw fields (also the 9-bit immediate)
module decode_stage
    import decode_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush,
    input  logic [INST_W-1:0] instruction,
    input  logic [DATA_W-1:0] alu_fwd_result,
    input  logic [ADR_W-1:0]  alu_fwd_adr,
    input  logic              alu_fwd_we,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADR_W-1:0]  wb_adr,
    input  logic              wb_we,
    output logic [DATA_W-1:0] regA,
    output logic [DATA_W-1:0] regB,
    output logic [COP_W-1:0]  cop,
    output logic [ADR_W-1:0]  destReg_adr,
    output logic              we,
    output logic [ADR_W-1:0]  regA_adr,
    output logic [ADR_W-1:0]  regB_adr,
    output logic [ADR_W-1:0]  inst_freeBits
);

    logic [INST_W-1:0] ir_q;
    logic              ir_valid_q;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q       <= NOP_WORD;
            ir_valid_q <= 1'b0;
        end else if (flush) begin
            ir_q       <= NOP_WORD;
            ir_valid_q <= 1'b0;
        end else if (enable) begin
            ir_q       <= instruction;
            ir_valid_q <= 1'b1;
        end
    end

    always_comb begin
        cop           = ir_q[COP_MSB:COP_LSB];
        destReg_adr   = ir_q[DEST_MSB:DEST_LSB];
        regA_adr      = ir_q[SRCA_MSB:SRCA_LSB];
        regB_adr      = ir_q[SRCB_MSB:SRCB_LSB];
        inst_freeBits = ir_q[FREE_MSB:FREE_LSB];
        // A bubble still drives operands; only the write enable is suppressed.
        we            = ir_valid_q && (ir_q[COP_MSB:COP_LSB] != NOP_COP);
    end

    // Writeback bypass lives in the register file; ALU forwarding sits on top of it.
    decode_stage_regfile u_regfile (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wb_we),
        .wr_adr    (wb_adr),
        .wr_data   (wb_data),
        .rd_adr_a  (ir_q[SRCA_MSB:SRCA_LSB]),
        .rd_data_a (rf_a),
        .rd_adr_b  (ir_q[SRCB_MSB:SRCB_LSB]),
        .rd_data_b (rf_b)
    );

    always_comb begin
        regA = select_operand(alu_fwd_we, alu_fwd_adr, alu_fwd_result,
                              ir_q[SRCA_MSB:SRCA_LSB], rf_a);
        regB = select_operand(alu_fwd_we, alu_fwd_adr, alu_fwd_result,
                              ir_q[SRCB_MSB:SRCB_LSB], rf_b);
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed literal checks plus randomized
// traffic compared every cycle against a behavioural model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        flush;
    logic [15:0] instruction;
    logic [15:0] alu_fwd_result;
    logic [2:0]  alu_fwd_adr;
    logic        alu_fwd_we;
    logic [15:0] wb_data;
    logic [2:0]  wb_adr;
    logic        wb_we;
    logic [15:0] regA;
    logic [15:0] regB;
    logic [3:0]  cop;
    logic [2:0]  destReg_adr;
    logic        we;
    logic [2:0]  regA_adr;
    logic [2:0]  regB_adr;
    logic [2:0]  inst_freeBits;

    int compared   = 0;
    int mismatched = 0;
    bit check_en   = 1'b0;

    decode_stage dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .flush          (flush),
        .instruction    (instruction),
        .alu_fwd_result (alu_fwd_result),
        .alu_fwd_adr    (alu_fwd_adr),
        .alu_fwd_we     (alu_fwd_we),
        .wb_data        (wb_data),
        .wb_adr         (wb_adr),
        .wb_we          (wb_we),
        .regA           (regA),
        .regB           (regB),
        .cop            (cop),
        .destReg_adr    (destReg_adr),
        .we             (we),
        .regA_adr       (regA_adr),
        .regB_adr       (regB_adr),
        .inst_freeBits  (inst_freeBits)
    );

    always #5 clk = ~clk;

    // Behavioural model: architectural registers, the latched word and its valid flag.
    logic [15:0] m_rf [8];
    logic [15:0] m_ir;
    logic        m_valid;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) m_rf[i] <= 16'h0000;
            m_ir    <= 16'hF000;
            m_valid <= 1'b0;
        end else begin
            if (wb_we) m_rf[wb_adr] <= wb_data;
            if (flush) begin
                m_ir    <= 16'hF000;
                m_valid <= 1'b0;
            end else if (enable) begin
                m_ir    <= instruction;
                m_valid <= 1'b1;
            end
        end
    end

    function automatic logic [15:0] exp_operand(input logic [2:0] src);
        if (alu_fwd_we && alu_fwd_adr == src) return alu_fwd_result;
        if (wb_we && wb_adr == src) return wb_data;
        return m_rf[src];
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("m_cop",  16'(cop),           16'(m_ir[15:12]));
            chk("m_dest", 16'(destReg_adr),   16'(m_ir[11:9]));
            chk("m_srca", 16'(regA_adr),      16'(m_ir[8:6]));
            chk("m_srcb", 16'(regB_adr),      16'(m_ir[5:3]));
            chk("m_free", 16'(inst_freeBits), 16'(m_ir[2:0]));
            chk("m_we",   16'(we),            16'(m_valid && m_ir[15:12] != 4'hF));
            chk("m_regA", regA,               exp_operand(m_ir[8:6]));
            chk("m_regB", regB,               exp_operand(m_ir[5:3]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        enable = 1'b0; flush = 1'b0; instruction = 16'h0000;
        alu_fwd_we = 1'b0; alu_fwd_adr = 3'd0; alu_fwd_result = 16'h0000;
        wb_we = 1'b0; wb_adr = 3'd0; wb_data = 16'h0000;
    endtask

    task automatic random_cycle();
        enable         = ($urandom_range(0, 3) != 0);
        flush          = ($urandom_range(0, 15) == 0);
        instruction    = 16'($urandom);
        alu_fwd_we     = 1'($urandom_range(0, 1));
        alu_fwd_adr    = 3'($urandom_range(0, 7));
        alu_fwd_result = 16'($urandom);
        wb_we          = 1'($urandom_range(0, 1));
        wb_adr         = 3'($urandom_range(0, 7));
        wb_data        = 16'($urandom);
        step();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        check_en = 1'b1;

        // Reset state
        sample();
        chk("rst_cop",  16'(cop),         16'h000F);
        chk("rst_we",   16'(we),          16'h0000);
        chk("rst_regA", regA,             16'h0000);
        chk("rst_regB", regB,             16'h0000);
        chk("rst_dest", 16'(destReg_adr), 16'h0000);

        // Regfile write then read: R3 = 1234, load cop=1 dest=0 srcA=3
        wb_we = 1'b1; wb_adr = 3'd3; wb_data = 16'h1234;
        step();
        wb_we = 1'b0; instruction = 16'h10C0; enable = 1'b1;
        step();
        enable = 1'b0;
        sample();
        chk("rf_regA", regA,     16'h1234);
        chk("rf_we",   16'(we),  16'h0001);
        chk("rf_cop",  16'(cop), 16'h0001);

        // Writeback bypass on srcB=5
        instruction = 16'h2828; enable = 1'b1;
        step();
        enable = 1'b0;
        wb_we = 1'b1; wb_adr = 3'd5; wb_data = 16'hBEEF;
        sample();
        chk("byp_regB", regB, 16'hBEEF);
        step();
        wb_we = 1'b0;
        sample();
        chk("byp_stored", regB, 16'hBEEF);

        // Forward priority on srcA=2
        instruction = 16'h4280; enable = 1'b1;
        step();
        enable = 1'b0;
        alu_fwd_we = 1'b1; alu_fwd_adr = 3'd2; alu_fwd_result = 16'h00AA;
        wb_we = 1'b1; wb_adr = 3'd2; wb_data = 16'h0055;
        sample();
        chk("fwd_alu", regA, 16'h00AA);
        alu_fwd_we = 1'b0;
        #1;
        chk("fwd_wb", regA, 16'h0055);
        step();
        wb_we = 1'b0;

        // Immediate-format instruction: cop=3 dest=1 fields 5,3,2
        instruction = 16'h335A; enable = 1'b1;
        step();
        enable = 1'b0;
        sample();
        chk("imm_a",    16'(regA_adr),      16'h0005);
        chk("imm_b",    16'(regB_adr),      16'h0003);
        chk("imm_free", 16'(inst_freeBits), 16'h0002);
        chk("imm_we",   16'(we),            16'h0001);
        chk("imm_dest", 16'(destReg_adr),   16'h0001);

        // Hold with enable low
        instruction = 16'hABCD;
        step();
        sample();
        chk("hold_cop", 16'(cop),      16'h0003);
        chk("hold_a",   16'(regA_adr), 16'h0005);

        // Flush overrides enable
        instruction = 16'h10C0; enable = 1'b1; flush = 1'b1;
        step();
        enable = 1'b0; flush = 1'b0;
        sample();
        chk("flush_cop", 16'(cop), 16'h000F);
        chk("flush_we",  16'(we),  16'h0000);

        // Random traffic
        repeat (1500) random_cycle();

        // Asynchronous reset in the middle of a cycle
        idle();
        #2 reset = 1'b0;
        #1;
        chk("arst_cop",  16'(cop), 16'h000F);
        chk("arst_we",   16'(we),  16'h0000);
        chk("arst_regA", regA,     16'h0000);
        chk("arst_regB", regB,     16'h0000);
        step();
        reset = 1'b1;

        repeat (1500) random_cycle();
        idle();
        step();
        check_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
